// File: rtl/fifo_rd_pkg.sv
// -----------------------------------------------------------------------------
// fifo_rd_pkg
// Shared definitions for the FIFO read-side controller: FSM state encoding,
// skid depth, statistics counter width and the read-credit helper.
// -----------------------------------------------------------------------------
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  localparam int SKID_DEPTH = 2;
  localparam int RD_CNT_W   = 16;

  // A new read may issue only if, after this cycle's downstream pop, the words
  // already owed to the skid (held + in flight) leave room for one more.
  function automatic logic credit_ok(input logic [1:0] occ,
                                     input logic       inflight,
                                     input logic       pop);
    return ({1'b0, occ} + {2'b00, inflight}) < ({2'b00, pop} + 3'd2);
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl_if
// Bundles the FIFO status/data side and the downstream valid/ready side of the
// read controller.
//   master : the controller (drives fifo_read_enable, out_*, busy, err)
//   slave  : the environment (FIFO + consumer + enable source)
// -----------------------------------------------------------------------------
interface fifo_rd_ctrl_if #(
  parameter int DATA_W = 10
);
  logic              enable;
  logic              fifo_empty;
  logic              fifo_almost_full;
  logic              fifo_error;
  logic [DATA_W-1:0] fifo_data_out;
  logic              fifo_read_enable;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              err;

  modport master (
    input  enable, fifo_empty, fifo_almost_full, fifo_error, fifo_data_out, out_ready,
    output fifo_read_enable, out_data, out_valid, busy, err
  );

  modport slave (
    output enable, fifo_empty, fifo_almost_full, fifo_error, fifo_data_out, out_ready,
    input  fifo_read_enable, out_data, out_valid, busy, err
  );
endinterface

// File: rtl/fifo_rd_skid.sv
// -----------------------------------------------------------------------------
// fifo_rd_skid
// Two-entry FIFO-ordered skid buffer that absorbs the FIFO's one-cycle read
// latency.
//   clk, reset   : clock, asynchronous active-low reset
//   i_push/i_din : capture a word
//   i_pop        : remove the head word (ignored when empty)
//   o_dout       : head word
//   o_occ        : number of held words (0..2)
//   o_overflow   : push while full without a simultaneous pop (word dropped)
// -----------------------------------------------------------------------------
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_din,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_dout,
  output logic [1:0]        o_occ,
  output logic              o_overflow
);

  logic [DATA_W-1:0] r_mem [SKID_DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;

  logic w_pop;
  logic w_full;
  logic w_push;

  assign w_pop      = i_pop && (r_occ != 2'd0);
  assign w_full     = (r_occ == 2'd2);
  assign w_push     = i_push && (!w_full || w_pop);
  assign o_overflow = i_push && w_full && !w_pop;
  assign o_dout     = r_mem[r_rd_ptr];
  assign o_occ      = r_occ;

  // Storage, pointers and occupancy; simultaneous push and pop keep occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_rd_ctrl
// Read-side controller for a synchronous FIFO. Issues read strobes in bursts
// (capped at BURST_LEN) or in an uncapped drain when the FIFO is almost full,
// captures the FIFO's data one cycle after each strobe into a 2-entry skid and
// presents words downstream on a valid/ready port.
//   clk      : clock, all logic on posedge
//   reset    : asynchronous active-low reset
//   bus      : fifo_rd_ctrl_if.master (enable, FIFO status/data, read strobe,
//              downstream out_data/out_valid/out_ready, busy, sticky err)
//   rd_count : downstream handshake counter (only with FIFO_RD_STATS_EN)
// Optional feature macro: FIFO_RD_STATS_EN
// -----------------------------------------------------------------------------
module fifo_rd_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W    = 10,
  parameter int BURST_LEN = 4
) (
  input  logic                clk,
  input  logic                reset,
  fifo_rd_ctrl_if.master      bus
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [RD_CNT_W-1:0] rd_count
`endif
);

  localparam int BC_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  rd_state_e         r_state;
  logic [BC_W-1:0]   r_burst_cnt;
  logic              r_inflight;
  logic              r_err;

  logic [DATA_W-1:0] w_dout;
  logic [1:0]        w_occ;
  logic              w_overflow;
  logic              w_pop;
  logic              w_rd_en;
  logic              w_last;

  assign w_pop   = bus.out_valid && bus.out_ready;
  // Credit counts this cycle's pop so reads sustain one word per cycle.
  assign w_rd_en = ((r_state == BURST) || (r_state == DRAIN)) && bus.enable &&
                   !bus.fifo_empty && credit_ok(w_occ, r_inflight, w_pop);
  assign w_last  = w_rd_en && (r_burst_cnt == BC_W'(BURST_LEN - 1));

  assign bus.fifo_read_enable = w_rd_en;
  assign bus.out_data         = w_dout;
  assign bus.out_valid        = (w_occ != 2'd0);
  assign bus.busy             = (r_state != IDLE) || r_inflight || (w_occ != 2'd0);
  assign bus.err              = r_err;

  fifo_rd_skid #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .i_push     (r_inflight),
    .i_din      (bus.fifo_data_out),
    .i_pop      (w_pop),
    .o_dout     (w_dout),
    .o_occ      (w_occ),
    .o_overflow (w_overflow)
  );

  // Read FSM and burst counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.enable && bus.fifo_almost_full) begin
            r_state <= DRAIN;
          end else if (bus.enable && !bus.fifo_empty) begin
            r_state     <= BURST;
            r_burst_cnt <= '0;
          end else begin
            r_state <= IDLE;
          end
        end
        BURST: begin
          if (w_rd_en) begin
            r_burst_cnt <= r_burst_cnt + BC_W'(1);
          end
          if (bus.fifo_almost_full) begin
            r_state <= DRAIN;
          end else if (w_last || bus.fifo_empty || !bus.enable) begin
            r_state <= IDLE;
          end else begin
            r_state <= BURST;
          end
        end
        DRAIN: begin
          if (bus.fifo_empty || !bus.enable) begin
            r_state <= IDLE;
          end else begin
            r_state <= DRAIN;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_burst_cnt <= '0;
        end
      endcase
    end
  end

  // In-flight flag (data arrives the cycle after the strobe) and sticky error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_inflight <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (bus.fifo_error || w_overflow) begin
        r_err <= 1'b1;
      end
    end
  end

`ifdef FIFO_RD_STATS_EN
  logic [RD_CNT_W-1:0] r_rd_count;

  // Downstream handshake counter, wraps naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_count <= '0;
    end else if (w_pop) begin
      r_rd_count <= r_rd_count + RD_CNT_W'(1);
    end
  end

  assign rd_count = r_rd_count;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_rd_ctrl
// Self-checking bench for fifo_rd_ctrl. A behavioural FIFO (array + pointers)
// feeds the controller; a queue of written words is the expected downstream
// order. Directed scenarios are followed by a randomized phase.
// -----------------------------------------------------------------------------
module tb_fifo_rd_ctrl;

  localparam int DATA_W = 10;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fifo_rd_ctrl_if #(.DATA_W(DATA_W)) bus ();

`ifdef FIFO_RD_STATS_EN
  logic [15:0] rd_count;
`endif

  fifo_rd_ctrl #(
    .DATA_W    (DATA_W),
    .BURST_LEN (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
`ifdef FIFO_RD_STATS_EN
    ,
    .rd_count (rd_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Behavioural FIFO.
  logic [DATA_W-1:0] mem [256];
  logic [7:0]        wr_ptr = 8'd0;
  logic [7:0]        rd_ptr = 8'd0;
  logic [7:0]        fcount;
  int                af_thresh = 1000;

  assign fcount               = wr_ptr - rd_ptr;
  assign bus.fifo_empty       = (fcount == 8'd0);
  assign bus.fifo_almost_full = (int'(fcount) >= af_thresh);

  always @(posedge clk) begin
    if (bus.fifo_read_enable) begin
      bus.fifo_data_out <= mem[rd_ptr];
      rd_ptr            <= rd_ptr + 8'd1;
    end
  end

  // Reference: words leave in the order they were written.
  logic [DATA_W-1:0] exp_q [$];
  int rd_issued = 0;
  int delivered = 0;
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    mem[wr_ptr] = w;
    wr_ptr      = wr_ptr + 8'd1;
    exp_q.push_back(w);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Continuous checks at the falling edge: order, hold under stall, credit.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.fifo_read_enable) begin
        rd_issued++;
        chk("rd_when_empty", 32'(bus.fifo_empty), 32'd0);
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $error("FAIL spurious_out: observed=%0h expected=none", bus.out_data);
        end else begin
          chk("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        end
        delivered++;
      end
      chk("outstanding", 32'((rd_issued - delivered) <= 2), 32'd1);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !bus.busy) break;
      @(posedge clk);
    end
    #1;
    chk("drain_done", 32'(exp_q.size() == 0 && !bus.busy), 32'd1);
  endtask

  task automatic rec_rd(input int n, output logic [31:0] pat);
    pat = 32'd0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pat[i] = bus.fifo_read_enable;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0]       pat;
    logic [31:0]       vpat;
    logic [DATA_W-1:0] first;
    int                rd_before;

    bus.enable     = 1'b0;
    bus.out_ready  = 1'b1;
    bus.fifo_error = 1'b0;

    // Reset held with enable=1 and a non-empty FIFO.
    push_word(DATA_W'($urandom));
    push_word(DATA_W'($urandom));
    bus.enable = 1'b1;
    tick(3);
    chk("rst_rd_en", 32'(bus.fifo_read_enable), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_data", 32'(bus.out_data), 32'd0);
    reset = 1'b1;
    tick(1);
    chk("rst_exit_busy", 32'(bus.busy), 32'd1);
    chk("rst_exit_rd", 32'(bus.fifo_read_enable), 32'd1);
    wait_drain();
    bus.enable = 1'b0;
    tick(1);

    // Burst cap: 6 words -> 4 reads, one IDLE cycle, 2 reads.
    for (int i = 0; i < 6; i++) push_word(DATA_W'($urandom));
    tick(1);
    bus.enable = 1'b1;
    rec_rd(10, pat);
    chk("burst_pattern", pat, 32'h0000_00DE);
    wait_drain();
    bus.enable = 1'b0;
    tick(1);

    // Drain: almost full from the first word -> 8 back-to-back reads.
    af_thresh = 1;
    for (int i = 0; i < 8; i++) push_word(DATA_W'($urandom));
    tick(1);
    bus.enable = 1'b1;
    rec_rd(11, pat);
    chk("drain_pattern", pat, 32'h0000_01FE);
    wait_drain();
    bus.enable = 1'b0;
    af_thresh  = 1000;
    tick(1);

    // Backpressure: consumer stalled -> exactly two reads, head held.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push_word(DATA_W'($urandom));
    first     = exp_q[0];
    rd_before = rd_issued;
    tick(1);
    bus.enable = 1'b1;
    tick(12);
    chk("bp_reads", 32'(rd_issued - rd_before), 32'd2);
    chk("bp_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_data", 32'(bus.out_data), 32'(first));
    bus.out_ready = 1'b1;
    wait_drain();
    chk("bp_err", 32'(bus.err), 32'd0);
    bus.enable = 1'b0;
    tick(1);

    // Single word: one read, out_valid two cycles after leaving IDLE.
    push_word(DATA_W'($urandom));
    tick(1);
    bus.enable = 1'b1;
    vpat = 32'd0;
    pat  = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pat[i]  = bus.fifo_read_enable;
      vpat[i] = bus.out_valid;
    end
    chk("single_rd", pat, 32'h0000_0002);
    chk("single_valid", vpat, 32'h0000_0008);
    wait_drain();
    tick(1);

    // Randomized traffic with enable and ready toggling.
    af_thresh = 6;
    for (int c = 0; c < 400; c++) begin
      bus.enable    = ($urandom_range(9) != 0);
      bus.out_ready = ($urandom_range(9) < 7);
      if (fcount < 8'd12 && $urandom_range(2) == 0) push_word(DATA_W'($urandom));
      tick(1);
    end
    bus.enable    = 1'b1;
    bus.out_ready = 1'b1;
    wait_drain();
    chk("rand_err", 32'(bus.err), 32'd0);
    chk("rand_fifo_empty", 32'(fcount), 32'd0);

`ifdef FIFO_RD_STATS_EN
    chk("rd_count", 32'(rd_count), 32'(delivered[15:0]));
`endif

    // Sticky error from a FIFO error pulse, cleared only by reset.
    bus.fifo_error = 1'b1;
    tick(1);
    bus.fifo_error = 1'b0;
    chk("err_set", 32'(bus.err), 32'd1);
    tick(5);
    chk("err_sticky", 32'(bus.err), 32'd1);
    reset = 1'b0;
    tick(1);
    chk("err_cleared", 32'(bus.err), 32'd0);
`ifdef FIFO_RD_STATS_EN
    chk("rd_count_rst", 32'(rd_count), 32'd0);
`endif
    reset = 1'b1;
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
